// File: rtl/mem_access_seq_pkg.sv
// mem_access_seq_pkg: shared widths, access/state enums, request record and byte-lane helper.
package mem_seq_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 3;
    typedef enum logic [1:0] {acc_FETCH, acc_READ, acc_WRITE, acc_RSVD} access_t;
    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, ERR} seq_state_t;
    typedef struct packed {
        access_t             kind;
        logic                wide;
        logic [ADDR_W-1:0]   addr;
        logic [2*DATA_W-1:0] wdata;
    } mem_req_t;
    function automatic logic [DATA_W-1:0] byte_lane(input logic [2*DATA_W-1:0] w, input logic hi);
        return hi ? w[2*DATA_W-1:DATA_W] : w[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: request/response handshake and byte-wide memory bus of the sequencer.
interface mem_access_seq_if;
    import mem_seq_pkg::*;
    logic                req_valid, req_ready, req_wide, busy;
    access_t             req_kind, rsp_kind;
    logic [ADDR_W-1:0]   req_addr, mem_addr;
    logic [2*DATA_W-1:0] req_wdata, rsp_rdata;
    logic [WAIT_W-1:0]   wait_cfg;
    logic                rsp_valid, rsp_err, mem_re, mem_we;
    logic [DATA_W-1:0]   mem_wdata, mem_rdata;
    modport slave(
        input  req_valid, req_kind, req_wide, req_addr, req_wdata, wait_cfg, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_kind, rsp_rdata, mem_addr, mem_re, mem_we, mem_wdata, busy
    );
    modport master(
        output req_valid, req_kind, req_wide, req_addr, req_wdata, wait_cfg, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_kind, rsp_rdata, mem_addr, mem_re, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/mem_access_seq_wait_timer.sv
// wait_timer: per-byte wait-state down-counter; done marks the final cycle of a byte phase.
module wait_timer
    import mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] count_in,
    output logic              done
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? count_in : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
    assign done = cnt_q == '0;
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: multi-cycle memory access sequencer with wait states and two-byte splitting.
module mem_access_seq
    import mem_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mem_access_seq_if.slave bus
);
    seq_state_t          state_q;
    mem_req_t            req_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   lo_q;
    logic                rsp_valid_q, rsp_err_q, mem_re_q, mem_we_q;
    access_t             rsp_kind_q;
    logic [2*DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q, addr_hi_d;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                accept, done, load, rd;
    assign accept    = bus.req_valid && state_q == IDLE;
    assign load      = accept || (state_q == ACC_LO && done && req_q.wide);
    assign addr_hi_d = req_q.addr + 1'b1;
    assign rd        = req_q.kind != acc_WRITE;
    wait_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .count_in (accept ? bus.wait_cfg : wait_q),
        .done     (done)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            wait_q      <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_kind_q  <= acc_FETCH;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    req_q  <= '{kind: bus.req_kind, wide: bus.req_wide, addr: bus.req_addr, wdata: bus.req_wdata};
                    wait_q <= bus.wait_cfg;
                    if (bus.req_kind == acc_RSVD) begin
                        state_q <= ERR;
                    end else begin
                        state_q     <= ACC_LO;
                        mem_addr_q  <= bus.req_addr;
                        mem_wdata_q <= byte_lane(bus.req_wdata, 1'b0);
                        mem_re_q    <= bus.req_kind != acc_WRITE;
                        mem_we_q    <= bus.req_kind == acc_WRITE;
                    end
                end
                ACC_LO: if (done) begin
                    lo_q <= bus.mem_rdata;
                    if (req_q.wide) begin
                        state_q     <= ACC_HI;
                        mem_addr_q  <= addr_hi_d;
                        mem_wdata_q <= byte_lane(req_q.wdata, 1'b1);
                    end else begin
                        state_q     <= IDLE;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_kind_q  <= req_q.kind;
                        rsp_rdata_q <= rd ? {{DATA_W{1'b0}}, bus.mem_rdata} : '0;
                    end
                end
                ACC_HI: if (done) begin
                    state_q     <= IDLE;
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_kind_q  <= req_q.kind;
                    rsp_rdata_q <= rd ? {bus.mem_rdata, lo_q} : '0;
                end
                ERR: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_kind_q  <= req_q.kind;
                    rsp_rdata_q <= '0;
                end
            endcase
        end
    end
    assign bus.req_ready = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_kind  = rsp_kind_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table vectors plus corner sequences, checked against a response scoreboard.
module tb_mem_access_seq;
    import mem_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vec = 0;
    int   miss = 0;
    logic [7:0] mem [0:65535];
    mem_access_seq_if bus();
    mem_access_seq dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.mem_rdata = mem[bus.mem_addr];
    // Memory model: known contents restored on every reset, byte writes otherwise.
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h1000] <= 8'hA5; mem[16'h1001] <= 8'h5A;
            mem[16'h2000] <= 8'h77; mem[16'h2001] <= 8'h88;
            mem[16'hFFFF] <= 8'h99; mem[16'h0000] <= 8'h66;
            mem[16'h0100] <= 8'h3C; mem[16'h0200] <= 8'h11;
            mem[16'h0201] <= 8'h22; mem[16'h0300] <= 8'h5E;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    typedef struct {
        access_t     kind;
        logic        wide;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  wt;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    typedef struct {
        access_t     kind;
        logic        err;
        logic [15:0] rdata;
        int          at;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[10];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask
    function automatic int lat(input access_t k, input logic w, input logic [2:0] wt);
        return k == acc_RSVD ? 2 : (w ? 2 * (int'(wt) + 1) + 1 : int'(wt) + 2);
    endfunction
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.mem_re || bus.mem_we) chk("re_we_excl", 32'(bus.mem_re & bus.mem_we), 0);
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", cyc, e.at);
                chk("rsp_kind", 32'(bus.rsp_kind), 32'(e.kind));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            end
        end
    endtask
    task automatic send(input access_t k, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [2:0] wt, input logic [15:0] er, input logic ee, input bit hold,
                        output int ca);
        int n = 0;
        tick();
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.req_wide  = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.wait_cfg  = wt;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            ca = -1;
            return;
        end
        ca = cyc + 1;
        sb.push_back('{kind: k, err: ee, rdata: er, at: ca + lat(k, w, wt) - 1});
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask
    initial begin
        int ca, cb;
        bus.req_valid = 1'b0;
        bus.req_kind  = acc_FETCH;
        bus.req_wide  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.wait_cfg  = '0;
        tbl[0] = '{acc_READ,  1'b0, 16'h1000, 16'h0000, 3'd0, 16'h00A5, 1'b0};
        tbl[1] = '{acc_FETCH, 1'b1, 16'h1000, 16'h0000, 3'd3, 16'h5AA5, 1'b0};
        tbl[2] = '{acc_WRITE, 1'b0, 16'h3000, 16'h1234, 3'd1, 16'h0000, 1'b0};
        tbl[3] = '{acc_READ,  1'b0, 16'h3000, 16'h0000, 3'd0, 16'h0034, 1'b0};
        tbl[4] = '{acc_WRITE, 1'b1, 16'h3001, 16'hCAFE, 3'd7, 16'h0000, 1'b0};
        tbl[5] = '{acc_READ,  1'b1, 16'h3001, 16'h0000, 3'd2, 16'hCAFE, 1'b0};
        tbl[6] = '{acc_RSVD,  1'b1, 16'h2000, 16'hFFFF, 3'd4, 16'h0000, 1'b1};
        tbl[7] = '{acc_FETCH, 1'b0, 16'h2001, 16'h0000, 3'd5, 16'h0088, 1'b0};
        tbl[8] = '{acc_READ,  1'b1, 16'h2000, 16'h0000, 3'd0, 16'h8877, 1'b0};
        tbl[9] = '{acc_READ,  1'b1, 16'hFFFF, 16'h0000, 3'd4, 16'h6699, 1'b0};
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_strobes", 32'({bus.mem_re, bus.mem_we}), 0);
        chk("rst_data", {bus.mem_addr, bus.rsp_rdata}, 0);
        chk("rst_misc", 32'({bus.mem_wdata, bus.rsp_kind, bus.rsp_err}), 0);
        foreach (tbl[i])
            send(tbl[i].kind, tbl[i].wide, tbl[i].addr, tbl[i].wdata, tbl[i].wt,
                 tbl[i].exp_rdata, tbl[i].exp_err, 1'b0, ca);
        drain();
        send(acc_READ, 1'b0, 16'h0100, 16'h0, 3'd0, 16'h003C, 1'b0, 1'b0, ca);
        tick();
        chk("rd_re", 32'(bus.mem_re), 1);
        chk("rd_we", 32'(bus.mem_we), 0);
        chk("rd_addr", 32'(bus.mem_addr), 32'h0100);
        tick();
        chk("rd_re_drop", 32'(bus.mem_re), 0);
        drain();
        send(acc_WRITE, 1'b1, 16'hFFFF, 16'hBEEF, 3'd2, 16'h0000, 1'b0, 1'b0, ca);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ww_we", 32'({bus.mem_we, bus.mem_re}), 32'b10);
            chk("ww_addr", 32'(bus.mem_addr), i < 3 ? 32'hFFFF : 32'h0000);
            chk("ww_wdata", 32'(bus.mem_wdata), i < 3 ? 32'hEF : 32'hBE);
        end
        drain();
        chk("ww_mem_lo", 32'(mem[16'hFFFF]), 32'hEF);
        chk("ww_mem_hi", 32'(mem[16'h0000]), 32'hBE);
        send(acc_FETCH, 1'b1, 16'h0200, 16'h0, 3'd0, 16'h2211, 1'b0, 1'b0, ca);
        send(acc_READ, 1'b0, 16'h0300, 16'h0, 3'd0, 16'h005E, 1'b0, 1'b0, cb);
        chk("b2b_accept", cb, ca + 3);
        drain();
        send(acc_RSVD, 1'b0, 16'h4000, 16'h1234, 3'd5, 16'h0000, 1'b1, 1'b0, ca);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_strobes", 32'({bus.mem_re, bus.mem_we}), 0);
        end
        drain();
        send(acc_READ, 1'b0, 16'h1000, 16'h0, 3'd1, 16'h00A5, 1'b0, 1'b1, ca);
        send(acc_WRITE, 1'b1, 16'h5000, 16'h2211, 3'd0, 16'h0000, 1'b0, 1'b0, cb);
        chk("held_accept", cb, ca + 3);
        drain();
        chk("held_mem", 32'({mem[16'h5001], mem[16'h5000]}), 32'h2211);
        send(acc_READ, 1'b1, 16'h1000, 16'h0, 3'd1, 16'h5AA5, 1'b0, 1'b0, ca);
        repeat (3) tick();
        chk("hi_addr", 32'(bus.mem_addr), 32'h1001);
        chk("hi_re", 32'(bus.mem_re), 1);
        rst = 1'b1;
        sb.delete();
        tick();
        chk("mid_rst_strobes", 32'({bus.mem_re, bus.mem_we}), 0);
        chk("mid_rst_ready", 32'(bus.req_ready), 1);
        chk("mid_rst_rsp", 32'(bus.rsp_valid), 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("no_partial_rsp", 32'(bus.busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
